fp8_e4m3_divider: RTL and testbench

Iterative FP8 E4M3 divider computing quotient = a / b. It is the inverse-direction companion to the E4M3 adder and multiplier in the nf_tpu datapath, used for normalisation and scale-factor computation. It sits behind a valid/ready handshake and uses a multi-cycle restoring mantissa division. Format rules match the FP8 arithmetic blocks: saturation, no NaN/Inf, truncation rounding.

---
 rtl/fp8_e4m3_divider.sv | 148 ++++++++++++++
 tb/tb_fp8_e4m3_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp8_e4m3_divider.sv
// fp8_e4m3_divider
//   Iterative FP8 E4M3 divider, quotient = a / b. A restoring mantissa
//   divider produces one quotient bit per cycle over five cycles. Results
//   saturate to {sign, SAT_MAG} on overflow or divide-by-zero, flush to
//   8'h00 on underflow, and are truncated (no rounding). Denormal operands
//   (exponent field 0) are treated as zero.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any in-flight op
//   in_valid   operand pair valid
//   in_ready   high while idle; operands captured on in_valid & in_ready
//   a          dividend, E4M3 {sign, exp[3:0], frac[2:0]}, bias 7
//   b          divisor, E4M3
//   out_valid  quotient valid (held until out_ready)
//   out_ready  consumer accepts quotient
//   quotient   E4M3 result, stable while out_valid is high

module fp8_e4m3_divider #(
  parameter logic [6:0] SAT_MAG = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient
);

  typedef enum logic [1:0] {IDLE, SPECIAL, DIV, DONE} state_t;

  state_t            state;
  logic              sign;
  logic [4:0]        rem;
  logic [3:0]        mb;
  logic [4:0]        q;
  logic signed [5:0] exp_q;
  logic [2:0]        iter;
  logic [7:0]        special_result;

  logic              a_zero;
  logic              b_zero;
  logic signed [5:0] exp_in;

  logic              step_bit;
  logic [4:0]        rem_sub;
  logic [4:0]        rem_next;
  logic [4:0]        q_next;
  logic signed [5:0] exp_out;
  logic [2:0]        frac_out;
  logic [7:0]        final_result;

  assign in_ready = (state == IDLE);

  // Operand decode at the input port. The biased exponent difference is
  // formed in signed 6-bit arithmetic so the full -7..21 range is kept
  // without wrapping.
  always_comb begin
    a_zero = (a[6:3] == 4'd0);
    b_zero = (b[6:3] == 4'd0);
    exp_in = $signed({2'b00, a[6:3]}) - $signed({2'b00, b[6:3]}) + 6'sd7;
  end

  // One restoring-division step, plus the normalisation and range handling
  // applied to the step's result. The latter only matters on the fifth step,
  // where q_next holds floor(ma*16/mb) in 8..31: if its MSB is clear the
  // quotient was below 1.0 and the exponent drops by one.
  always_comb begin
    step_bit = (rem >= {1'b0, mb});
    rem_sub  = step_bit ? (rem - {1'b0, mb}) : rem;
    rem_next = rem_sub << 1;
    q_next   = {q[3:0], step_bit};
    if (q_next[4]) begin
      frac_out = q_next[3:1];
      exp_out  = exp_q;
    end else begin
      frac_out = q_next[2:0];
      exp_out  = exp_q - 6'sd1;
    end
    if (exp_out >= 6'sd15) begin
      final_result = {sign, SAT_MAG};
    end else if (exp_out <= 6'sd0) begin
      final_result = 8'h00;
    end else begin
      final_result = {sign, exp_out[3:0], frac_out};
    end
  end

  // Control FSM and datapath registers. Operands are latched only on the
  // accept edge, so input activity during SPECIAL/DIV/DONE has no effect.
  // The zero-operand result is resolved at accept time and simply published
  // one cycle later from SPECIAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      quotient       <= 8'h00;
      sign           <= 1'b0;
      rem            <= 5'd0;
      mb             <= 4'd0;
      q              <= 5'd0;
      exp_q          <= 6'sd0;
      iter           <= 3'd0;
      special_result <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign           <= a[7] ^ b[7];
            rem            <= {2'b01, a[2:0]};
            mb             <= {1'b1, b[2:0]};
            q              <= 5'd0;
            exp_q          <= exp_in;
            iter           <= 3'd0;
            special_result <= b_zero ? {a[7] ^ b[7], SAT_MAG} : 8'h00;
            state          <= (a_zero || b_zero) ? SPECIAL : DIV;
          end
        end
        SPECIAL: begin
          quotient  <= special_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DIV: begin
          rem  <= rem_next;
          q    <= q_next;
          iter <= iter + 3'd1;
          if (iter == 3'd4) begin
            quotient  <= final_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_e4m3_divider.sv
// tb_fp8_e4m3_divider
//   Self-checking bench for fp8_e4m3_divider: a table of directed vectors,
//   hand-written backpressure / ignored-input / reset-abort sequences, and
//   randomized operands checked against an arithmetic reference model.

module tb_fp8_e4m3_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    int         lat;
  } vec_t;

  vec_t vecs [13];

  fp8_e4m3_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference quotient from the format rules: the true ratio of the two
  // mantissas scaled by 16, truncated, then placed at the exponent implied
  // by its magnitude.
  function automatic logic [7:0] refQuotient(input logic [7:0] x, input logic [7:0] y);
    int   ea;
    int   eb;
    int   ma;
    int   mb;
    int   qv;
    int   eo;
    int   fr;
    logic s;
    ea = int'(x[6:3]);
    eb = int'(y[6:3]);
    s  = x[7] ^ y[7];
    if (eb == 0) return {s, 7'h7F};
    if (ea == 0) return 8'h00;
    ma = 8 + int'(x[2:0]);
    mb = 8 + int'(y[2:0]);
    qv = (ma * 16) / mb;
    if (qv >= 16) begin
      fr = (qv / 2) % 8;
      eo = ea - eb + 7;
    end else begin
      fr = qv % 8;
      eo = ea - eb + 6;
    end
    if (eo >= 15) return {s, 7'h7F};
    if (eo <= 0) return 8'h00;
    return {s, 4'(eo), 3'(fr)};
  endfunction

  function automatic int refLatency(input logic [7:0] x, input logic [7:0] y);
    return (x[6:3] == 4'd0 || y[6:3] == 4'd0) ? 2 : 6;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Runs one operation starting at a negedge in IDLE. out_ready is held low
  // for 'hold' cycles once the result appears; with 'noise' set, random
  // in_valid/a/b activity is driven while the op is in flight.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [7:0] expq, input int explat,
                               input int hold, input bit noise, input string tag);
    int cycles;
    bit ready_low;
    checkOutput($sformatf("%s in_ready idle", tag), 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    cycles    = 1;
    ready_low = 1'b1;
    while (!out_valid && cycles < 20) begin
      if (in_ready) ready_low = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = 8'($urandom);
        b        = 8'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput($sformatf("%s latency", tag), 32'(cycles), 32'(explat));
    checkOutput($sformatf("%s in_ready busy", tag), 32'(ready_low), 32'd1);
    checkOutput($sformatf("%s quotient", tag), 32'(quotient), 32'(expq));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput($sformatf("%s hold%0d out_valid", tag, h), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s hold%0d quotient", tag, h), 32'(quotient), 32'(expq));
      checkOutput($sformatf("%s hold%0d in_ready", tag, h), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("%s out_valid drop", tag), 32'(out_valid), 32'd0);
    checkOutput($sformatf("%s back to idle", tag), 32'(in_ready), 32'd1);
  endtask

  // Main sequence: reset, directed table, corner sequences, random ops.
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0]  = '{8'h40, 8'h38, 8'h40, 6};
    vecs[1]  = '{8'h38, 8'h44, 8'h2A, 6};
    vecs[2]  = '{8'hC0, 8'h38, 8'hC0, 6};
    vecs[3]  = '{8'h38, 8'h00, 8'h7F, 2};
    vecs[4]  = '{8'hB8, 8'h00, 8'hFF, 2};
    vecs[5]  = '{8'h00, 8'hB8, 8'h00, 2};
    vecs[6]  = '{8'h00, 8'h00, 8'h7F, 2};
    vecs[7]  = '{8'h70, 8'h08, 8'h7F, 6};
    vecs[8]  = '{8'h08, 8'h70, 8'h00, 6};
    vecs[9]  = '{8'h38, 8'h3F, 8'h30, 6};
    vecs[10] = '{8'h40, 8'h40, 8'h38, 6};
    vecs[11] = '{8'h05, 8'h38, 8'h00, 2};
    vecs[12] = '{8'hB8, 8'h03, 8'hFF, 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'h00);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat, 0, 1'b0,
                    $sformatf("vec%0d", i));
    end

    applyStimulus(8'h40, 8'h38, 8'h40, 6, 4, 1'b0, "backpressure");
    applyStimulus(8'h38, 8'h44, 8'h2A, 6, 0, 1'b1, "noise div");
    applyStimulus(8'hB8, 8'h00, 8'hFF, 2, 0, 1'b1, "noise special");

    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h70;
    b         = 8'h08;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort quotient", 32'(quotient), 32'h00);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    applyStimulus(8'h40, 8'h40, 8'h38, 6, 0, 1'b0, "reaccept");

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, refQuotient(ra, rb), refLatency(ra, rb),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d %02h/%02h", i, ra, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
